calc2_port_initiator: RTL and testbench

Single-port request initiator for the calc2 four-port calculator. It accepts operations on a valid/ready front end and serialises each one into the two-cycle calc2 request sequence with an allocated 2-bit tag. It tracks up to four outstanding tags, matches out-of-order calc2 responses back to their originating command, and presents one completed result per cycle. One instance connects to each calc2 port (a–d), in place of bench-driven stimulus, for on-chip traffic generation and self-check.

---
 rtl/calc2_port_initiator_if.sv | 42 ++++
 rtl/calc2_port_initiator.sv | 183 ++++++++++++++++++
 tb/tb_calc2_port_initiator.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/calc2_port_initiator_if.sv
// Port bundle between a calc2 port initiator and its surroundings: op front end,
// calc2 request/response wires, and the completion/status outputs.
interface calc2_port_initiator_if #(
   parameter int DATA_W = 32
);
   logic              op_valid;
   logic              op_ready;
   logic [3:0]        op_cmd;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;

   logic [3:0]        reqcmd;
   logic [DATA_W-1:0] req_data;
   logic [1:0]        reqtag;

   logic [1:0]        out_resp;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        out_tag;

   logic              rsp_valid;
   logic [3:0]        rsp_cmd;
   logic [1:0]        rsp_resp;
   logic [DATA_W-1:0] rsp_data;
   logic [1:0]        rsp_tag;
   logic              rsp_timeout;
   logic              err_unexpected;
   logic              busy;

   modport master (
      input  op_valid, op_cmd, op_a, op_b, out_resp, out_data, out_tag,
      output op_ready, reqcmd, req_data, reqtag,
      output rsp_valid, rsp_cmd, rsp_resp, rsp_data, rsp_tag, rsp_timeout,
      output err_unexpected, busy
   );

   modport slave (
      output op_valid, op_cmd, op_a, op_b, out_resp, out_data, out_tag,
      input  op_ready, reqcmd, req_data, reqtag,
      input  rsp_valid, rsp_cmd, rsp_resp, rsp_data, rsp_tag, rsp_timeout,
      input  err_unexpected, busy
   );
endinterface

// File: rtl/calc2_port_initiator.sv
// calc2 single-port initiator: issues tagged two-cycle requests, tracks four tags and
// matches responses. Define CALC2_INIT_TIMEOUT_EN to build per-tag age timeouts.
module calc2_port_initiator #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input logic                    c_clk,
   input logic                    reset,
   calc2_port_initiator_if.master bus
);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

   state_t            state_q, state_d;
   logic [3:0]        tag_vld_q, tag_vld_d;
   logic [3:0][3:0]   tag_cmd_q, tag_cmd_d;
   logic [3:0]        cur_cmd_q, cur_cmd_d;
   logic [DATA_W-1:0] cur_a_q, cur_a_d;
   logic [DATA_W-1:0] cur_b_q, cur_b_d;
   logic [1:0]        cur_tag_q, cur_tag_d;

   logic              rsp_valid_q, rsp_valid_d;
   logic [3:0]        rsp_cmd_q, rsp_cmd_d;
   logic [1:0]        rsp_resp_q, rsp_resp_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [1:0]        rsp_tag_q, rsp_tag_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              err_q, err_d;

   logic              any_free;
   logic [1:0]        free_idx;
   logic              op_ready_w;
   logic              accept;
   logic [3:0]        expired;

   // Freedom is judged on start-of-cycle valid bits, so a tag retired this cycle
   // cannot be handed out again until the next one.
   always_comb begin
      any_free = ~&tag_vld_q;
      free_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!tag_vld_q[i]) free_idx = 2'(i);
      end
   end

   assign op_ready_w = reset && (state_q != S_CMD) && any_free;
   assign accept     = bus.op_valid && op_ready_w;

`ifdef CALC2_INIT_TIMEOUT_EN
   localparam int AGE_W = $clog2(TIMEOUT + 1);

   logic [3:0][AGE_W-1:0] age_q, age_d;

   // Age is 0 in the CMD cycle; expiry is flagged one cycle early so the registered
   // completion lands exactly TIMEOUT cycles after CMD. Count saturates at TIMEOUT.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         age_d[i]   = age_q[i];
         expired[i] = tag_vld_q[i] && (age_q[i] >= AGE_W'(TIMEOUT - 1));
         if (accept && (free_idx == 2'(i)))
            age_d[i] = '0;
         else if (tag_vld_q[i] && (age_q[i] != AGE_W'(TIMEOUT)))
            age_d[i] = age_q[i] + AGE_W'(1);
      end
   end

   always_ff @(posedge c_clk) begin
      if (!reset) age_q <= '0;
      else        age_q <= age_d;
   end
`else
   assign expired = '0;
   if (TIMEOUT < 2) begin : g_timeout_unused
   end
`endif

   always_comb begin
      state_d       = state_q;
      tag_vld_d     = tag_vld_q;
      tag_cmd_d     = tag_cmd_q;
      cur_cmd_d     = cur_cmd_q;
      cur_a_d       = cur_a_q;
      cur_b_d       = cur_b_q;
      cur_tag_d     = cur_tag_q;
      rsp_valid_d   = 1'b0;
      rsp_cmd_d     = 4'd0;
      rsp_resp_d    = 2'd0;
      rsp_data_d    = '0;
      rsp_tag_d     = 2'd0;
      rsp_timeout_d = 1'b0;
      err_d         = 1'b0;

      case (state_q)
         S_IDLE:  if (accept) state_d = S_CMD;
         S_CMD:   state_d = S_DATA;
         S_DATA:  state_d = accept ? S_CMD : S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         cur_cmd_d           = bus.op_cmd;
         cur_a_d             = bus.op_a;
         cur_b_d             = bus.op_b;
         cur_tag_d           = free_idx;
         tag_vld_d[free_idx] = 1'b1;
         tag_cmd_d[free_idx] = bus.op_cmd;
      end

      // Allocation only touches a tag invalid at cycle start and retirement only a
      // valid one, so both can update the table in the same cycle.
      if (bus.out_resp != 2'd0) begin
         if (tag_vld_q[bus.out_tag]) begin
            rsp_valid_d            = 1'b1;
            rsp_cmd_d              = tag_cmd_q[bus.out_tag];
            rsp_resp_d             = bus.out_resp;
            rsp_data_d             = bus.out_data;
            rsp_tag_d              = bus.out_tag;
            tag_vld_d[bus.out_tag] = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end

      if (!rsp_valid_d && (|expired)) begin
         for (int i = 3; i >= 0; i--) begin
            if (expired[i]) rsp_tag_d = 2'(i);
         end
         rsp_valid_d            = 1'b1;
         rsp_timeout_d          = 1'b1;
         rsp_cmd_d              = tag_cmd_q[rsp_tag_d];
         tag_vld_d[rsp_tag_d]   = 1'b0;
      end
   end

   always_ff @(posedge c_clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         tag_vld_q     <= '0;
         tag_cmd_q     <= '0;
         cur_cmd_q     <= '0;
         cur_a_q       <= '0;
         cur_b_q       <= '0;
         cur_tag_q     <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_cmd_q     <= '0;
         rsp_resp_q    <= '0;
         rsp_data_q    <= '0;
         rsp_tag_q     <= '0;
         rsp_timeout_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         tag_vld_q     <= tag_vld_d;
         tag_cmd_q     <= tag_cmd_d;
         cur_cmd_q     <= cur_cmd_d;
         cur_a_q       <= cur_a_d;
         cur_b_q       <= cur_b_d;
         cur_tag_q     <= cur_tag_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_cmd_q     <= rsp_cmd_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_data_q    <= rsp_data_d;
         rsp_tag_q     <= rsp_tag_d;
         rsp_timeout_q <= rsp_timeout_d;
         err_q         <= err_d;
      end
   end

   assign bus.op_ready       = op_ready_w;
   assign bus.reqcmd         = (state_q == S_CMD) ? cur_cmd_q : 4'd0;
   assign bus.req_data       = (state_q == S_CMD)  ? cur_a_q :
                               (state_q == S_DATA) ? cur_b_q : '0;
   assign bus.reqtag         = (state_q != S_IDLE) ? cur_tag_q : 2'd0;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_cmd        = rsp_cmd_q;
   assign bus.rsp_resp       = rsp_resp_q;
   assign bus.rsp_data       = rsp_data_q;
   assign bus.rsp_tag        = rsp_tag_q;
   assign bus.rsp_timeout    = rsp_timeout_q;
   assign bus.err_unexpected = err_q;
   assign bus.busy           = (state_q != S_IDLE) || (|tag_vld_q);

endmodule

// File: tb/tb_calc2_port_initiator.sv
// Directed bench for calc2_port_initiator; the timeout scenario runs on a second
// instance with TIMEOUT=16 when CALC2_INIT_TIMEOUT_EN is defined.
module tb_calc2_port_initiator;

   logic c_clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 c_clk = ~c_clk;

   calc2_port_initiator_if #(.DATA_W(32)) bus ();
   calc2_port_initiator_if #(.DATA_W(32)) bus2 ();

   calc2_port_initiator #(.DATA_W(32), .TIMEOUT(255)) u_dut (
      .c_clk (c_clk),
      .reset (reset),
      .bus   (bus.master)
   );

   calc2_port_initiator #(.DATA_W(32), .TIMEOUT(16)) u_to (
      .c_clk (c_clk),
      .reset (reset),
      .bus   (bus2.master)
   );

   int ord     [4] = '{3, 1, 0, 2};
   int exp_cmd [4] = '{4, 5, 9, 7};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      bus.op_valid = 1'b0;  bus.op_cmd = 4'd0; bus.op_a = 32'd0; bus.op_b = 32'd0;
      bus.out_resp = 2'd0;  bus.out_data = 32'd0; bus.out_tag = 2'd0;
      bus2.op_valid = 1'b0; bus2.op_cmd = 4'd0; bus2.op_a = 32'd0; bus2.op_b = 32'd0;
      bus2.out_resp = 2'd0; bus2.out_data = 32'd0; bus2.out_tag = 2'd0;
      repeat (3) tick();
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_busy",      32'(bus.busy), 0);
      chk("rst_reqcmd",    32'(bus.reqcmd), 0);
      chk("rst_err",       32'(bus.err_unexpected), 0);
      chk("rst_op_ready",  32'(bus.op_ready), 0);
      reset = 1'b1;
      #1;
      chk("rel_op_ready",  32'(bus.op_ready), 1);

      // single add
      bus.op_valid = 1'b1; bus.op_cmd = 4'd1; bus.op_a = 32'd5; bus.op_b = 32'd3;
      tick();
      bus.op_valid = 1'b0;
      chk("add_cmd_reqcmd", 32'(bus.reqcmd), 1);
      chk("add_cmd_data",   bus.req_data, 5);
      chk("add_cmd_tag",    32'(bus.reqtag), 0);
      chk("add_busy",       32'(bus.busy), 1);
      tick();
      chk("add_dat_reqcmd", 32'(bus.reqcmd), 0);
      chk("add_dat_data",   bus.req_data, 3);
      tick();
      chk("add_idle_data",  bus.req_data, 0);
      bus.out_resp = 2'd1; bus.out_data = 32'd8; bus.out_tag = 2'd0;
      tick();
      bus.out_resp = 2'd0;
      chk("add_rsp_valid",  32'(bus.rsp_valid), 1);
      chk("add_rsp_cmd",    32'(bus.rsp_cmd), 1);
      chk("add_rsp_resp",   32'(bus.rsp_resp), 1);
      chk("add_rsp_data",   bus.rsp_data, 8);
      chk("add_rsp_tag",    32'(bus.rsp_tag), 0);
      chk("add_rsp_to",     32'(bus.rsp_timeout), 0);
      tick();
      chk("add_rsp_pulse",  32'(bus.rsp_valid), 0);
      chk("add_busy_done",  32'(bus.busy), 0);

      // back-to-back fill of all four tags
      bus.op_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.op_cmd = 4'(k + 4); bus.op_a = 32'(k); bus.op_b = 32'(k + 100);
         chk("b2b_ready", 32'(bus.op_ready), 1);
         tick();
         chk("b2b_tag",       32'(bus.reqtag), 32'(k));
         chk("b2b_cmd",       32'(bus.reqcmd), 32'(k + 4));
         chk("b2b_ready_cmd", 32'(bus.op_ready), 0);
         tick();
         chk("b2b_data", bus.req_data, 32'(k + 100));
      end
      chk("full_ready_dat", 32'(bus.op_ready), 0);
      tick();
      chk("full_ready_idle", 32'(bus.op_ready), 0);
      bus.out_resp = 2'd1; bus.out_data = 32'h22; bus.out_tag = 2'd2;
      tick();
      bus.out_resp = 2'd0;
      chk("t2_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("t2_rsp_tag",   32'(bus.rsp_tag), 2);
      chk("t2_rsp_cmd",   32'(bus.rsp_cmd), 6);
      chk("t2_ready",     32'(bus.op_ready), 1);
      bus.op_cmd = 4'd9;
      tick();
      bus.op_valid = 1'b0;
      chk("fifth_tag", 32'(bus.reqtag), 2);
      chk("fifth_cmd", 32'(bus.reqcmd), 9);
      tick();
      tick();

      // drain all four out of order
      for (int k = 0; k < 4; k++) begin
         bus.out_resp = 2'd1; bus.out_tag = 2'(ord[k]); bus.out_data = 32'(48 + ord[k]);
         tick();
         chk("drain_valid", 32'(bus.rsp_valid), 1);
         chk("drain_tag",   32'(bus.rsp_tag), 32'(ord[k]));
         chk("drain_cmd",   32'(bus.rsp_cmd), 32'(exp_cmd[ord[k]]));
         chk("drain_data",  bus.rsp_data, 32'(48 + ord[k]));
      end
      bus.out_resp = 2'd0;
      tick();
      chk("drain_busy", 32'(bus.busy), 0);

      // out-of-order pair
      bus.op_valid = 1'b1; bus.op_cmd = 4'd1; bus.op_a = 32'd1; bus.op_b = 32'd2;
      tick();
      bus.op_cmd = 4'd3;
      tick();
      tick();
      bus.op_valid = 1'b0;
      chk("ooo_tag1", 32'(bus.reqtag), 1);
      tick();
      tick();
      bus.out_resp = 2'd1; bus.out_tag = 2'd1; bus.out_data = 32'h10;
      tick();
      bus.out_resp = 2'd1; bus.out_tag = 2'd0; bus.out_data = 32'h20;
      chk("ooo1_valid", 32'(bus.rsp_valid), 1);
      chk("ooo1_tag",   32'(bus.rsp_tag), 1);
      chk("ooo1_cmd",   32'(bus.rsp_cmd), 3);
      chk("ooo1_data",  bus.rsp_data, 32'h10);
      tick();
      bus.out_resp = 2'd0;
      chk("ooo2_valid", 32'(bus.rsp_valid), 1);
      chk("ooo2_tag",   32'(bus.rsp_tag), 0);
      chk("ooo2_cmd",   32'(bus.rsp_cmd), 1);
      chk("ooo2_data",  bus.rsp_data, 32'h20);

      // unexpected response on a free tag
      bus.out_resp = 2'd1; bus.out_tag = 2'd3; bus.out_data = 32'h33;
      tick();
      bus.out_resp = 2'd0;
      chk("unx_err",   32'(bus.err_unexpected), 1);
      chk("unx_rsp",   32'(bus.rsp_valid), 0);
      chk("unx_busy",  32'(bus.busy), 0);
      tick();
      chk("unx_pulse", 32'(bus.err_unexpected), 0);

      // reset during DATA of the second outstanding op
      bus.op_valid = 1'b1; bus.op_cmd = 4'd2; bus.op_a = 32'd7; bus.op_b = 32'd9;
      tick();
      tick();
      tick();
      bus.op_valid = 1'b0;
      chk("mid_tag",  32'(bus.reqtag), 1);
      tick();
      chk("mid_data", bus.req_data, 9);
      reset = 1'b0;
      tick();
      chk("mid_rst_reqcmd", 32'(bus.reqcmd), 0);
      chk("mid_rst_data",   bus.req_data, 0);
      chk("mid_rst_busy",   32'(bus.busy), 0);
      chk("mid_rst_rsp",    32'(bus.rsp_valid), 0);
      reset = 1'b1;
      #1;
      chk("mid_rel_ready", 32'(bus.op_ready), 1);
      bus.op_valid = 1'b1; bus.op_cmd = 4'd5;
      tick();
      bus.op_valid = 1'b0;
      chk("mid_realloc_tag", 32'(bus.reqtag), 0);
      chk("mid_realloc_cmd", 32'(bus.reqcmd), 5);
      tick();
      tick();

`ifdef CALC2_INIT_TIMEOUT_EN
      bus2.op_valid = 1'b1; bus2.op_cmd = 4'd5; bus2.op_a = 32'd1; bus2.op_b = 32'd1;
      tick();
      bus2.op_valid = 1'b0;
      chk("to_cmd_tag", 32'(bus2.reqtag), 0);
      repeat (15) tick();
      chk("to_early", 32'(bus2.rsp_valid), 0);
      tick();
      chk("to_valid",   32'(bus2.rsp_valid), 1);
      chk("to_flag",    32'(bus2.rsp_timeout), 1);
      chk("to_resp",    32'(bus2.rsp_resp), 0);
      chk("to_data",    bus2.rsp_data, 0);
      chk("to_tag",     32'(bus2.rsp_tag), 0);
      chk("to_cmd",     32'(bus2.rsp_cmd), 5);
      bus2.out_resp = 2'd1; bus2.out_tag = 2'd0; bus2.out_data = 32'd4;
      tick();
      bus2.out_resp = 2'd0;
      chk("to_busy",    32'(bus2.busy), 0);
      chk("to_late_err", 32'(bus2.err_unexpected), 1);
      chk("to_late_rsp", 32'(bus2.rsp_valid), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
